// File: rtl/datapath.sv
`default_nettype none
// datapath: 16-bit execution datapath with an 8x16 register file, A/B operand
// registers, B-path shifter, 4-function ALU, result register C and zero flag.
// Revision: 1.0
module datapath (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  readnum,
  input  logic        vsel,
  input  logic        loada,
  input  logic        loadb,
  input  logic [1:0]  shift,
  input  logic        asel,
  input  logic        bsel,
  input  logic [1:0]  ALUop,
  input  logic        loadc,
  input  logic        loads,
  input  logic [2:0]  writenum,
  input  logic        write,
  input  logic [15:0] datapath_in,
  output logic        Z_out,
  output logic [15:0] datapath_out
);

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  logic [15:0] rf_q [8];
  logic [15:0] a_q, b_q, c_q;
  logic        z_q;

  logic [15:0] data_in_d;
  logic [15:0] data_out;
  logic [15:0] sout;
  logic [15:0] ain;
  logic [15:0] bin;
  logic [15:0] alu_d;
  logic        z_d;

  assign data_in_d = vsel ? datapath_in : c_q;
  // Plain array read: a register being written shows its old value until the edge.
  assign data_out  = rf_q[readnum];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= '0;
      end
    end else if (write) begin
      rf_q[writenum] <= data_in_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (loada) a_q <= data_out;
      if (loadb) b_q <= data_out;
    end
  end

  always_comb begin
    sout = b_q;
    unique case (shift)
      SH_PASS: sout = b_q;
      SH_LSL:  sout = {b_q[14:0], 1'b0};
      SH_LSR:  sout = {1'b0, b_q[15:1]};
      SH_ASR:  sout = {b_q[15], b_q[15:1]};
      default: sout = b_q;
    endcase
  end

  assign ain = asel ? 16'd0 : a_q;
  assign bin = bsel ? {11'b0, datapath_in[4:0]} : sout;

  always_comb begin
    alu_d = '0;
    unique case (ALUop)
      ALU_ADD: alu_d = ain + bin;
      ALU_SUB: alu_d = ain - bin;
      ALU_AND: alu_d = ain & bin;
      ALU_NOT: alu_d = ~bin;
      default: alu_d = '0;
    endcase
  end

  assign z_d = (alu_d == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
      z_q <= 1'b0;
    end else begin
      if (loadc) c_q <= alu_d;
      if (loads) z_q <= z_d;
    end
  end

  assign datapath_out = c_q;
  assign Z_out        = z_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
// tb_datapath: directed, table-driven checks of the datapath with hand-computed
// expected results, plus a hand-written mid-run asynchronous reset sequence.
module tb_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  readnum = '0;
  logic        vsel = 1'b0;
  logic        loada = 1'b0;
  logic        loadb = 1'b0;
  logic [1:0]  shift = '0;
  logic        asel = 1'b0;
  logic        bsel = 1'b0;
  logic [1:0]  ALUop = '0;
  logic        loadc = 1'b0;
  logic        loads = 1'b0;
  logic [2:0]  writenum = '0;
  logic        write = 1'b0;
  logic [15:0] datapath_in = '0;
  logic        Z_out;
  logic [15:0] datapath_out;

  int checks = 0;
  int errors = 0;

  datapath dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .readnum      (readnum),
    .vsel         (vsel),
    .loada        (loada),
    .loadb        (loadb),
    .shift        (shift),
    .asel         (asel),
    .bsel         (bsel),
    .ALUop        (ALUop),
    .loadc        (loadc),
    .loads        (loads),
    .writenum     (writenum),
    .write        (write),
    .datapath_in  (datapath_in),
    .Z_out        (Z_out),
    .datapath_out (datapath_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        vsel;
    logic [15:0] din;
    logic        write;
    logic [2:0]  wnum;
    logic [2:0]  rnum;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [1:0]  aluop;
    logic        loadc;
    logic        loads;
    bit          chk;
    logic [15:0] eo;
    logic        ez;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic v, input logic [15:0] din,
                     input logic wr, input logic [2:0] wn, input logic [2:0] rn,
                     input logic la, input logic lb, input logic [1:0] sh,
                     input logic as, input logic bs, input logic [1:0] op,
                     input logic lc, input logic ls, input bit chk,
                     input logic [15:0] eo, input logic ez);
    vec_t t;
    t.name = name; t.vsel = v; t.din = din; t.write = wr; t.wnum = wn;
    t.rnum = rn; t.loada = la; t.loadb = lb; t.shift = sh; t.asel = as;
    t.bsel = bs; t.aluop = op; t.loadc = lc; t.loads = ls; t.chk = chk;
    t.eo = eo; t.ez = ez;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [15:0] eo, input logic ez);
    checks++;
    if (datapath_out !== eo || Z_out !== ez) begin
      errors++;
      $display("FAIL %s: got out=%h Z=%b, expected out=%h Z=%b",
               name, datapath_out, Z_out, eo, ez);
    end
  endtask

  task automatic apply(input vec_t t);
    vsel = t.vsel; datapath_in = t.din; write = t.write; writenum = t.wnum;
    readnum = t.rnum; loada = t.loada; loadb = t.loadb; shift = t.shift;
    asel = t.asel; bsel = t.bsel; ALUop = t.aluop; loadc = t.loadc;
    loads = t.loads;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled 1 unit after the next.
  task automatic run_table();
    foreach (vecs[i]) begin
      apply(vecs[i]);
      @(posedge clk);
      #1;
      if (vecs[i].chk) check(vecs[i].name, vecs[i].eo, vecs[i].ez);
    end
    vecs.delete();
  endtask

  initial begin
    // name            v  din       wr wn rn la lb sh as bs op lc ls chk eo       ez
    add("wr_r0",        1, 16'd7,    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0);
    add("wr_r1_ldb_r0", 1, 16'd2,    1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0);
    add("lda_r1",       0, 16'd0,    0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0);
    add("add_shl",      0, 16'd0,    0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 16'h0010, 0);
    add("wb_r2",        0, 16'd0,    1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0010, 0);
    add("ldb_r2",       0, 16'd0,    0, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0010, 0);
    add("not_r2",       0, 16'd0,    0, 0, 0, 0, 0, 0, 1, 0, 3, 1, 1, 1, 16'hFFEF, 0);
    add("wr_r3",        1, 16'h8005, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFEF, 0);
    add("ldb_r3",       0, 16'd0,    0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'hFFEF, 0);
    add("shift_pass",   0, 16'd0,    0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 16'h8005, 0);
    add("shift_lsl",    0, 16'd0,    0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 16'h000A, 0);
    add("shift_lsr",    0, 16'd0,    0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 1, 1, 16'h4002, 0);
    add("shift_asr",    0, 16'd0,    0, 0, 0, 0, 0, 3, 1, 0, 0, 1, 1, 1, 16'hC002, 0);
    add("wr_r4",        1, 16'd5,    1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hC002, 0);
    add("ldab_r4",      0, 16'd0,    0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 16'hC002, 0);
    add("alu_sub",      0, 16'd0,    0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 16'h0000, 1);
    add("alu_and",      0, 16'd0,    0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 1, 16'h0005, 0);
    add("alu_not",      0, 16'd0,    0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 1, 16'hFFFA, 0);
    add("wr_r5",        1, 16'hFFFF, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFA, 0);
    add("wr_r6",        1, 16'd1,    1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFA, 0);
    add("lda_r5",       0, 16'd0,    0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFA, 0);
    add("ldb_r6",       0, 16'd0,    0, 0, 6, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'hFFFA, 0);
    add("add_wrap",     0, 16'd0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 16'h0000, 1);
    add("imm_add",      0, 16'hFFF3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 16'h0013, 0);
    add("hold_cs",      0, 16'd0,    0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 1, 16'h0013, 0);
    add("loads_only",   0, 16'd0,    0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 16'h0013, 1);
    add("loadc_only",   0, 16'd0,    0, 0, 0, 0, 0, 0, 1, 1, 3, 1, 0, 1, 16'hFFFF, 1);
    add("wb_with_ldc",  0, 16'd5,    1, 7, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 16'h0005, 0);
    add("ldb_r7",       0, 16'd0,    0, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0005, 0);
    add("out_r7_old_c", 0, 16'd0,    0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 16'hFFFF, 0);
    add("no_write",     1, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFF, 0);
    add("ldb_r0",       0, 16'd0,    0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'hFFFF, 0);
    add("out_r0_kept",  0, 16'd0,    0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 16'h0007, 0);
    add("wr_rd_same",   1, 16'h00AA, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0007, 0);
    add("out_pre_edge", 0, 16'd0,    0, 0, 0, 0, 0, 0, 1, 0, 3, 1, 1, 1, 16'hFFF8, 0);
    add("ldb_r0_new",   0, 16'd0,    0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'hFFF8, 0);
    add("out_post_edge",0, 16'd0,    0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 16'h00AA, 0);
    add("z_set",        0, 16'd0,    0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 16'h00AA, 1);

    repeat (2) @(posedge clk);
    #1;
    check("reset_initial", 16'h0000, 1'b0);
    rst_n = 1'b1;

    run_table();

    // Mid-run asynchronous reset: outputs clear before any edge and stay clear
    // across an edge even with every enable asserted.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", 16'h0000, 1'b0);
    vsel = 1'b1; datapath_in = 16'd9; write = 1'b1; writenum = 3'd0;
    loada = 1'b1; loadb = 1'b1; asel = 1'b1; bsel = 1'b1; ALUop = 2'b00;
    loadc = 1'b1; loads = 1'b1;
    @(posedge clk);
    #1;
    check("reset_dominates", 16'h0000, 1'b0);
    rst_n = 1'b1;

    add("b_after_reset",0, 16'd0,    0, 0, 0, 0, 0, 0, 1, 0, 3, 1, 1, 1, 16'hFFFF, 0);
    add("a_after_reset",0, 16'd0,    0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 16'h0000, 1);
    for (int i = 0; i < 8; i++) begin
      add($sformatf("ldb_r%0d_rst", i), 0, 16'd1, 0, 0, 3'(i), 0, 1, 0, 1, 1, 0, 1, 1,
          1, 16'h0001, 0);
      add($sformatf("r%0d_after_reset", i), 0, 16'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1,
          1, 16'h0000, 1);
    end
    run_table();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/datapath.md
Name: datapath

Overview:
- 16-bit execution datapath of the simple RISC machine.
- Contains an 8-entry register file, A/B operand registers, a B-path shifter, operand muxes, a 4-function ALU, a result register C and a zero-status flag.
- Every control signal is driven by the external FSM controller; the datapath has no internal sequencing.

Parameters:
- none (width fixed at 16 bits, 8 registers)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- readnum  in  3  register-file read address
- vsel  in  1  write-back source: 1 = datapath_in, 0 = datapath_out
- loada  in  1  load enable for register A
- loadb  in  1  load enable for register B
- shift  in  2  shifter op on B
- asel  in  1  1 = Ain forced to 0; 0 = Ain is A
- bsel  in  1  1 = Bin is {11'b0, datapath_in[4:0]}; 0 = Bin is shifter output
- ALUop  in  2  ALU operation
- loadc  in  1  load enable for result register C
- loads  in  1  load enable for status register
- writenum  in  3  register-file write address
- write  in  1  register-file write enable
- datapath_in  in  16  external/immediate data
- Z_out  out  1  registered zero flag
- datapath_out  out  16  registered result (register C)

Behaviour:
- Reset: rst_n = 0 asynchronously clears R0..R7, A, B, C and status. datapath_out = 0 and Z_out = 0 while rst_n is low and until the next load. Reset dominates all enables.
- data_in = vsel ? datapath_in : datapath_out (combinational).
- Register file:
  - On posedge clk with write = 1, R[writenum] <= data_in.
  - data_out = R[readnum], combinational, no write-through bypass. Reading the register being written shows the old value until the edge, the new value after it.
- A <= data_out on posedge when loada = 1; B <= data_out on posedge when loadb = 1; otherwise hold. Both may load in the same cycle.
- Shifter on B (combinational, output sout):
  - 00: pass through
  - 01: B << 1, LSB = 0
  - 10: B >> 1, MSB = 0
  - 11: B >> 1, MSB = B[15] (arithmetic)
- Ain = asel ? 16'd0 : A.
- Bin = bsel ? {11'b0, datapath_in[4:0]} : sout.
- ALU, 16-bit modulo-2^16 (carry/borrow discarded):
  - 00: Ain + Bin
  - 01: Ain - Bin
  - 10: Ain & Bin
  - 11: ~Bin
- Z = (ALU out == 0).
- C <= ALU out when loadc = 1; status <= Z when loads = 1; independent enables, otherwise hold.
- datapath_out = C; Z_out = status.
- Latency: an operand in the register file reaches datapath_out 2 edges after readnum is presented (edge 1 loads A/B, edge 2 loads C). Write-back of C needs a third edge with vsel = 0.
- Simultaneous write-back and read of the same register: read returns the pre-edge value. Writing C back while loadc = 1 stores the pre-edge C.
- Control inputs that are X must not corrupt state whose enable is 0.

Test Plan:
- Reset: assert rst_n = 0 mid-run after loading registers -> datapath_out = 0, Z_out = 0 immediately; all R[i], A, B read back 0 after release.
- Program sequence:
  - vsel = 1, datapath_in = 7, writenum = 0, write = 1 -> R0 = 7; readnum = 0, loadb -> B = 7.
  - datapath_in = 2 into R1; readnum = 1, loada -> A = 2.
  - shift = 01, asel = bsel = 0, ALUop = 00, loadc = loads = 1 -> datapath_out = 16 (0x0010), Z_out = 0.
  - vsel = 0, writenum = 2, write = 1 -> R2 = 16.
- Shifter with B = 0x8005, asel = 1, ALUop = 00: shift 00 -> 0x8005; 01 -> 0x000A; 10 -> 0x4002; 11 -> 0xC002.
- ALU and Z with A = 5, B = 5, shift = 00:
  - SUB -> 0, Z_out = 1
  - AND -> 5, Z_out = 0
  - NOT -> 0xFFFA
  - ADD of 0xFFFF + 1 -> 0x0000, Z_out = 1 (wrap)
- Immediate path: bsel = 1, datapath_in = 0xFFF3, asel = 1, ADD -> datapath_out = 0x0013.
- Hold behaviour: loadc = 0, loads = 0 while ALU inputs change -> datapath_out/Z_out unchanged; write = 0 -> no register modified; same-cycle read of a written register shows the old value before the edge.
